// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_arb_pkg
// Shared types and constants for the IFU/LSU memory arbiter.
// Rev    : 1.0
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef enum logic {
        GNT_IFU = 1'b0,
        GNT_LSU = 1'b1
    } grant_e;

    localparam logic [1:0]  SIZE_B       = 2'd0;
    localparam logic [1:0]  SIZE_H       = 2'd1;
    localparam logic [1:0]  SIZE_W       = 2'd2;
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    // Timeout counter is never narrower than 8 bits.
    function automatic int cnt_width(input int limit);
        int w;
        w = $clog2(limit + 1);
        return (w < 8) ? 8 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_rr.sv
`default_nettype none
// ============================================================================
// Module : mem_arb_rr
// Two-way round-robin picker: a tie goes to the side not granted last.
// Rev    : 1.0
// ============================================================================
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  grant_e     i_last_grant,
    output grant_e     o_grant,
    output logic       o_valid
);

    always_comb begin
        o_valid = |i_req;
        o_grant = GNT_IFU;
        case (i_req)
            2'b10:   o_grant = GNT_LSU;
            2'b11:   o_grant = (i_last_grant == GNT_IFU) ? GNT_LSU : GNT_IFU;
            default: o_grant = GNT_IFU;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_arb.sv
`default_nettype none
// ============================================================================
// Module : mem_arb
// Shares one memory port between IFU and LSU, one transaction at a time.
// Option : define MEM_ARB_TIMEOUT_EN to bound the WAIT state (mem_err pulse).
// Rev    : 1.0
// ============================================================================
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ifu_reqValid,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_respValid,
    output logic [DATA_W-1:0] ifu_rdata,
    input  logic              lsu_reqValid,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [1:0]        lsu_size,
    input  logic              lsu_wen,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [3:0]        lsu_wmask,
    output logic              lsu_respValid,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              mem_reqValid,
    input  logic              mem_reqReady,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_size,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic              mem_respValid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_err
);

    state_e            r_state;
    grant_e            r_grant;
    grant_e            r_last_grant;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic              r_wen;
    logic [DATA_W-1:0] r_wdata;
    logic [3:0]        r_wmask;
    logic [DATA_W-1:0] r_ifu_rdata;
    logic [DATA_W-1:0] r_lsu_rdata;

    logic [1:0]        w_req;
    grant_e            w_pick;
    logic              w_pick_valid;
    logic              w_timeout;
    logic [DATA_W-1:0] w_resp_data;

    assign w_req = {lsu_reqValid, ifu_reqValid};

    mem_arb_rr u_rr (
        .i_req        (w_req),
        .i_last_grant (r_last_grant),
        .o_grant      (w_pick),
        .o_valid      (w_pick_valid)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int c_CNT_W = cnt_width(TIMEOUT_CYCLES);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_err;

    assign w_timeout   = (r_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_resp_data = mem_respValid ? mem_rdata : DATA_W'(TIMEOUT_DATA);
    assign mem_err     = r_err;

    // Counter sits at zero outside WAIT so it is clear on entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= (r_state == WAIT) && w_timeout && !mem_respValid;
            if (r_state == WAIT) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end
`else
    logic [31:0] w_timeout_cycles_unused;

    assign w_timeout               = 1'b0;
    assign w_resp_data             = mem_rdata;
    assign mem_err                 = 1'b0;
    assign w_timeout_cycles_unused = TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_grant      <= GNT_IFU;
            r_last_grant <= GNT_IFU;
            r_addr       <= '0;
            r_size       <= '0;
            r_wen        <= 1'b0;
            r_wdata      <= '0;
            r_wmask      <= '0;
            r_ifu_rdata  <= '0;
            r_lsu_rdata  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_valid) begin
                        r_grant      <= w_pick;
                        r_last_grant <= w_pick;
                        r_state      <= ISSUE;
                        if (w_pick == GNT_LSU) begin
                            r_addr  <= lsu_addr;
                            r_size  <= lsu_size;
                            r_wen   <= lsu_wen;
                            r_wdata <= lsu_wdata;
                            r_wmask <= lsu_wmask;
                        end else begin
                            r_addr  <= ifu_addr;
                            r_size  <= SIZE_W;
                            r_wen   <= 1'b0;
                            r_wdata <= '0;
                            r_wmask <= 4'hF;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_reqReady) begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_respValid || w_timeout) begin
                        if (r_grant == GNT_LSU) begin
                            r_lsu_rdata <= w_resp_data;
                        end else begin
                            r_ifu_rdata <= w_resp_data;
                        end
                        r_state <= RESP;
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem_reqValid  = (r_state == ISSUE);
    assign mem_addr      = r_addr;
    assign mem_size      = r_size;
    assign mem_wen       = r_wen;
    assign mem_wdata     = r_wdata;
    assign mem_wmask     = r_wmask;
    assign ifu_respValid = (r_state == RESP) && (r_grant == GNT_IFU);
    assign lsu_respValid = (r_state == RESP) && (r_grant == GNT_LSU);
    assign ifu_rdata     = r_ifu_rdata;
    assign lsu_rdata     = r_lsu_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arb.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_arb
// Self-checking bench for mem_arb: directed cases plus randomized rounds.
// Rev    : 1.0
// ============================================================================
module tb_mem_arb;

    localparam int TMO = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        ifu_reqValid;
    logic [31:0] ifu_addr;
    logic        ifu_respValid;
    logic [31:0] ifu_rdata;
    logic        lsu_reqValid;
    logic [31:0] lsu_addr;
    logic [1:0]  lsu_size;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic        lsu_respValid;
    logic [31:0] lsu_rdata;
    logic        mem_reqValid;
    logic        mem_reqReady;
    logic [31:0] mem_addr;
    logic [1:0]  mem_size;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_respValid;
    logic [31:0] mem_rdata;
    logic        mem_err;

    always #5 clock = ~clock;

    mem_arb #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .ifu_reqValid  (ifu_reqValid),
        .ifu_addr      (ifu_addr),
        .ifu_respValid (ifu_respValid),
        .ifu_rdata     (ifu_rdata),
        .lsu_reqValid  (lsu_reqValid),
        .lsu_addr      (lsu_addr),
        .lsu_size      (lsu_size),
        .lsu_wen       (lsu_wen),
        .lsu_wdata     (lsu_wdata),
        .lsu_wmask     (lsu_wmask),
        .lsu_respValid (lsu_respValid),
        .lsu_rdata     (lsu_rdata),
        .mem_reqValid  (mem_reqValid),
        .mem_reqReady  (mem_reqReady),
        .mem_addr      (mem_addr),
        .mem_size      (mem_size),
        .mem_wen       (mem_wen),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_respValid (mem_respValid),
        .mem_rdata     (mem_rdata),
        .mem_err       (mem_err)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    bit          m_last_lsu;
    logic [31:0] m_ifu_rdata;
    logic [31:0] m_lsu_rdata;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    // Reference arbitration rule: lone requester wins, a tie goes away from the last grant.
    function automatic bit rr_pick(input bit ifu, input bit lsu, input bit last_lsu);
        if (ifu && lsu) return !last_lsu;
        return lsu;
    endfunction

    task automatic do_reset();
        reset         = 1'b1;
        ifu_reqValid  = 1'b0;
        ifu_addr      = '0;
        lsu_reqValid  = 1'b0;
        lsu_addr      = '0;
        lsu_size      = '0;
        lsu_wen       = 1'b0;
        lsu_wdata     = '0;
        lsu_wmask     = '0;
        mem_reqReady  = 1'b0;
        mem_respValid = 1'b0;
        mem_rdata     = '0;
        tick();
        tick();
        reset       = 1'b0;
        m_last_lsu  = 1'b0;
        m_ifu_rdata = '0;
        m_lsu_rdata = '0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, {ifu_respValid, lsu_respValid, mem_reqValid, mem_err,
                              mem_wen, mem_size, mem_wmask}, 64'd0);
        check({tag, "_addr"}, mem_addr, 64'd0);
        check({tag, "_wdata"}, mem_wdata, 64'd0);
        check({tag, "_ifu_rdata"}, ifu_rdata, 64'd0);
        check({tag, "_lsu_rdata"}, lsu_rdata, 64'd0);
    endtask

    task automatic raise_ifu(input logic [31:0] a);
        ifu_addr     = a;
        ifu_reqValid = 1'b1;
    endtask

    task automatic raise_lsu(input logic [31:0] a, input logic [1:0] s, input logic w,
                             input logic [31:0] d, input logic [3:0] m);
        lsu_addr     = a;
        lsu_size     = s;
        lsu_wen      = w;
        lsu_wdata    = d;
        lsu_wmask    = m;
        lsu_reqValid = 1'b1;
    endtask

    task automatic raise_lsu_rand();
        raise_lsu($urandom, 2'($urandom_range(0, 2)), 1'($urandom), $urandom, 4'($urandom));
    endtask

    // Plays the memory for one transaction owned by `who` (1 = LSU) and checks it end to end.
    task automatic serve(input bit who, input int d1, input int d2, input int exp_issue,
                         input bit junk, input bit raise_other, input bit keep,
                         input logic [31:0] data, output int resp_cyc);
        logic [38:0] e_req;
        logic [31:0] e_wdata;
        int          guard;
        int          issue;
        resp_cyc = -1;
        if (who) begin
            e_req   = {lsu_addr, lsu_size, lsu_wen, lsu_wmask};
            e_wdata = lsu_wdata;
        end else begin
            e_req   = {ifu_addr, 2'd2, 1'b0, 4'hF};
            e_wdata = '0;
        end
        guard = 0;
        do begin
            tick();
            guard++;
        end while (!mem_reqValid && guard < 40);
        if (!mem_reqValid) begin
            check("issue_timeout", 64'd0, 64'd1);
            return;
        end
        issue = cyc;
        check("issue_cycle", issue, exp_issue);
        check("req_fields", {mem_addr, mem_size, mem_wen, mem_wmask}, e_req);
        check("req_wdata", mem_wdata, e_wdata);
        if (raise_other) begin
            if (who) raise_ifu($urandom);
            else     raise_lsu_rand();
        end
        mem_respValid = junk & 1'($urandom);
        mem_rdata     = $urandom;
        for (int k = 0; k < d1; k++) begin
            tick();
            check("issue_hold", {mem_reqValid, mem_addr, mem_size, mem_wen, mem_wmask},
                  {1'b1, e_req});
            mem_respValid = junk & 1'($urandom);
            mem_rdata     = $urandom;
        end
        mem_reqReady = 1'b1;
        tick();
        mem_reqReady  = 1'b0;
        mem_respValid = 1'b0;
        check("wait_no_req", mem_reqValid, 64'd0);
        for (int k = 0; k < d2; k++) begin
            check("wait_no_resp", {ifu_respValid, lsu_respValid}, 64'd0);
            tick();
        end
        mem_respValid = 1'b1;
        mem_rdata     = data;
        tick();
        mem_respValid = 1'b0;
        mem_rdata     = $urandom;
        if (who) m_lsu_rdata = data;
        else     m_ifu_rdata = data;
        m_last_lsu = who;
        resp_cyc   = cyc;
        check("resp_cycle", cyc, issue + d1 + d2 + 2);
        check("resp_valid", {ifu_respValid, lsu_respValid}, who ? 64'd1 : 64'd2);
        check("resp_ifu_rdata", ifu_rdata, m_ifu_rdata);
        check("resp_lsu_rdata", lsu_rdata, m_lsu_rdata);
        check("resp_err", mem_err, 64'd0);
        if (!keep) begin
            if (who) lsu_reqValid = 1'b0;
            else     ifu_reqValid = 1'b0;
        end
        tick();
        check("resp_pulse", {ifu_respValid, lsu_respValid}, 64'd0);
        check("hold_rdata", {ifu_rdata, lsu_rdata}, {m_ifu_rdata, m_lsu_rdata});
    endtask

    // pat: 1 IFU, 2 LSU, 3 tie, 4 IFU then LSU during issue, 5 LSU then IFU during issue
    task automatic run_round(input int pat);
        bit first;
        int rc;
        int t0;
        repeat ($urandom_range(0, 2)) tick();
        if (pat == 1 || pat == 3 || pat == 4) raise_ifu($urandom);
        if (pat == 2 || pat == 3 || pat == 5) raise_lsu_rand();
        t0    = cyc;
        first = rr_pick(ifu_reqValid, lsu_reqValid, m_last_lsu);
        serve(first, $urandom_range(0, 3), $urandom_range(0, 3), t0 + 1, 1'($urandom),
              pat >= 4, 1'b0, $urandom, rc);
        if (pat >= 3) begin
            serve(!first, $urandom_range(0, 3), $urandom_range(0, 3), rc + 2, 1'($urandom),
                  1'b0, 1'b0, $urandom, rc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int  rc;
        int  t0;
        bit  first;
        bit  seen;
        logic [31:0] d;

        do_reset();
        check_zero("reset");

        // IFU fetch against zero-wait memory.
        t0 = cyc;
        raise_ifu(32'h8000_0000);
        serve(1'b0, 0, 0, t0 + 1, 1'b0, 1'b0, 1'b0, 32'h0000_0013, rc);
        check("ifu_zero_wait_latency", rc - t0, 64'd3);

        // LSU halfword store with two cycles of back-pressure.
        t0 = cyc;
        raise_lsu(32'h0000_0100, 2'd1, 1'b1, 32'hAABB_CCDD, 4'b0011);
        serve(1'b1, 2, 0, t0 + 1, 1'b0, 1'b0, 1'b0, $urandom, rc);
        check("lsu_stall_latency", rc - t0, 64'd5);

        // Simultaneous requests right after reset, twice.
        do_reset();
        for (int r = 0; r < 2; r++) begin
            t0 = cyc;
            raise_ifu($urandom);
            raise_lsu_rand();
            first = rr_pick(1'b1, 1'b1, m_last_lsu);
            serve(first, 0, 0, t0 + 1, 1'b0, 1'b0, 1'b0, $urandom, rc);
            serve(!first, 0, 0, rc + 2, 1'b0, 1'b0, 1'b0, $urandom, rc);
        end

        // Request held past its response is taken as a fresh transaction.
        t0 = cyc;
        raise_ifu(32'h0000_2000);
        serve(1'b0, 0, 1, t0 + 1, 1'b0, 1'b0, 1'b1, $urandom, rc);
        serve(1'b0, 1, 0, rc + 2, 1'b0, 1'b0, 1'b0, $urandom, rc);

        // Reset while waiting on memory abandons the transaction.
        raise_ifu(32'h0000_3000);
        tick();
        check("rst_wait_issue", mem_reqValid, 64'd1);
        mem_reqReady = 1'b1;
        tick();
        mem_reqReady = 1'b0;
        reset        = 1'b1;
        ifu_reqValid = 1'b0;
        tick();
        reset       = 1'b0;
        m_last_lsu  = 1'b0;
        m_ifu_rdata = '0;
        m_lsu_rdata = '0;
        check_zero("rst_in_wait");
        mem_respValid = 1'b1;
        mem_rdata     = 32'h1234_5678;
        tick();
        mem_respValid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (ifu_respValid || lsu_respValid || mem_reqValid || ifu_rdata != 0 || lsu_rdata != 0)
                seen = 1'b1;
            tick();
        end
        check("rst_late_resp_ignored", seen, 64'd0);

`ifdef MEM_ARB_TIMEOUT_EN
        // Memory never answers: synthesized error response after TMO WAIT cycles.
        raise_ifu(32'h0000_4000);
        tick();
        mem_reqReady = 1'b1;
        tick();
        mem_reqReady = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < TMO; k++) begin
            if (ifu_respValid || lsu_respValid || mem_err) seen = 1'b1;
            tick();
        end
        check("tmo_quiet_in_wait", seen, 64'd0);
        check("tmo_resp", {ifu_respValid, lsu_respValid, mem_err}, 64'b101);
        check("tmo_rdata", ifu_rdata, 64'hDEAD_BEEF);
        m_ifu_rdata  = 32'hDEAD_BEEF;
        ifu_reqValid = 1'b0;
        tick();
        check("tmo_err_pulse", {ifu_respValid, mem_err}, 64'd0);

        // A response on the limit cycle is a normal response.
        raise_ifu(32'h0000_5000);
        tick();
        mem_reqReady = 1'b1;
        tick();
        mem_reqReady = 1'b0;
        repeat (TMO - 1) tick();
        d             = $urandom;
        mem_respValid = 1'b1;
        mem_rdata     = d;
        tick();
        mem_respValid = 1'b0;
        check("tmo_edge_resp", {ifu_respValid, mem_err}, 64'b10);
        check("tmo_edge_rdata", ifu_rdata, d);
        m_ifu_rdata  = d;
        ifu_reqValid = 1'b0;
        tick();
`else
        // Without the timeout option WAIT never gives up.
        raise_ifu(32'h0000_4000);
        tick();
        mem_reqReady = 1'b1;
        tick();
        mem_reqReady = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (ifu_respValid || lsu_respValid || mem_err || mem_reqValid) seen = 1'b1;
            tick();
        end
        check("no_tmo_wait_forever", seen, 64'd0);
        d             = $urandom;
        mem_respValid = 1'b1;
        mem_rdata     = d;
        tick();
        mem_respValid = 1'b0;
        check("no_tmo_late_resp", {ifu_respValid, mem_err}, 64'b10);
        check("no_tmo_rdata", ifu_rdata, d);
        m_ifu_rdata  = d;
        m_last_lsu   = 1'b0;
        ifu_reqValid = 1'b0;
        tick();
`endif

        for (int i = 0; i < 40; i++) begin
            run_round($urandom_range(1, 5));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
